// File: rtl/cvt_fp_ctrl_if.sv
// Request/response bus of cvt_fp_ctrl; the sticky-flag signals exist only
// when CVT_FP_STICKY_FLAGS_EN is defined.
interface cvt_fp_ctrl_if #(
    parameter int W        = 32,
    parameter int TAGWIDTH = 5
);
    // Valid/ready: a request transfers on any edge where ciReqValid and
    // coReqReady are both high, a response where coRspValid and ciRspReady are
    // both high; a valid that is not taken must be held by its producer.
    logic                ciReqValid;
    logic                coReqReady;
    logic                ciWay;
    logic [W-1:0]        diA;
    logic [TAGWIDTH-1:0] diTag;
    logic                coRspValid;
    logic                ciRspReady;
    logic [W-1:0]        doY;
    logic [TAGWIDTH-1:0] doTag;
    logic                doNAN;
    logic                doINF;
    logic                ciFlush;
    logic                coBusy;
    logic [1:0]          dbg_state;
`ifdef CVT_FP_STICKY_FLAGS_EN
    logic                ciFlagClr;
    logic                doStickyNAN;
    logic                doStickyINF;
`endif

    modport slave (
        input  ciReqValid, ciWay, diA, diTag, ciRspReady, ciFlush,
`ifdef CVT_FP_STICKY_FLAGS_EN
        input  ciFlagClr,
        output doStickyNAN, doStickyINF,
`endif
        output coReqReady, coRspValid, doY, doTag, doNAN, doINF, coBusy, dbg_state
    );

    modport master (
        output ciReqValid, ciWay, diA, diTag, ciRspReady, ciFlush,
`ifdef CVT_FP_STICKY_FLAGS_EN
        output ciFlagClr,
        input  doStickyNAN, doStickyINF,
`endif
        input  coReqReady, coRspValid, doY, doTag, doNAN, doINF, coBusy, dbg_state
    );
endinterface

// File: rtl/cvt_fp_ctrl.sv
// Two-tick int<->float conversion controller around one combinational converter.
// Optional sticky NaN/INF flags are enabled by defining CVT_FP_STICKY_FLAGS_EN.
module cvt_fp_conv #(
    parameter  int LOGWIDTH  = 5,
    parameter  int EXPWIDTH  = 8,
    parameter  int MANTWIDTH = 23,
    localparam int W         = 2**LOGWIDTH
) (
    input  logic         way,
    input  logic [W-1:0] a,
    output logic [W-1:0] y,
    output logic         nan,
    output logic         inf
);
    localparam int           BIAS     = 2**(EXPWIDTH-1) - 1;
    localparam logic [W-1:0] LOW_MASK = W'((64'd1 << (EXPWIDTH-1)) - 64'd1);
    localparam logic [W-1:0] MAX_POS  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};

    logic                 i_sign;
    logic [W-1:0]         i_mag;
    logic [W-1:0]         i_norm;
    int                   i_msb;
    logic [MANTWIDTH-1:0] i_mant;
    logic                 i_guard;
    logic                 i_sticky;
    logic                 i_rnd;
    logic [MANTWIDTH:0]   i_mant_r;
    logic [EXPWIDTH-1:0]  i_exp;
    logic [W-1:0]         i2f;

    // Word to float: round to nearest, ties to even.
    always_comb begin
        i_sign = a[W-1];
        i_mag  = i_sign ? (~a + 1'b1) : a;
        i_msb  = 0;
        for (int k = 0; k < W; k++) begin
            if (i_mag[k]) i_msb = k;
        end
        i_norm   = i_mag << (W - 1 - i_msb);
        i_mant   = i_norm[W-2 -: MANTWIDTH];
        i_guard  = i_norm[W-2-MANTWIDTH];
        i_sticky = |(i_norm & LOW_MASK);
        i_rnd    = i_guard & (i_sticky | i_mant[0]);
        i_mant_r = {1'b0, i_mant} + {{MANTWIDTH{1'b0}}, i_rnd};
        i_exp    = EXPWIDTH'(BIAS + i_msb) + EXPWIDTH'(i_mant_r[MANTWIDTH]);
        if (i_mag == '0) i2f = '0;
        else             i2f = {i_sign, i_exp, i_mant_r[MANTWIDTH-1:0]};
    end

    logic                 f_sign;
    logic [EXPWIDTH-1:0]  f_exp;
    logic [MANTWIDTH-1:0] f_mant;
    int                   f_ue;
    logic [W-1:0]         f_sig;
    logic [W-1:0]         f_mag;
    logic [W-1:0]         f2i;
    logic                 f_nan;
    logic                 f_inf;

    // Float to word: truncate toward zero, saturate on overflow/infinity,
    // NaN gives the largest positive word.
    always_comb begin
        f_sign = a[W-1];
        f_exp  = a[W-2 -: EXPWIDTH];
        f_mant = a[MANTWIDTH-1:0];
        f_ue   = int'(f_exp) - BIAS;
        f_sig  = W'({1'b1, f_mant});
        f_mag  = '0;
        f_nan  = 1'b0;
        f_inf  = 1'b0;
        f2i    = '0;
        if (f_exp == '1) begin
            if (f_mant != '0) begin
                f_nan = 1'b1;
                f2i   = MAX_POS;
            end else begin
                f_inf = 1'b1;
                f2i   = f_sign ? MIN_NEG : MAX_POS;
            end
        end else if (f_ue < 0) begin
            f2i = '0;
        end else if (f_ue >= W - 1) begin
            if (f_sign && f_ue == W - 1 && f_mant == '0) begin
                f2i = MIN_NEG;
            end else begin
                f_inf = 1'b1;
                f2i   = f_sign ? MIN_NEG : MAX_POS;
            end
        end else begin
            if (f_ue >= MANTWIDTH) f_mag = f_sig << (f_ue - MANTWIDTH);
            else                   f_mag = f_sig >> (MANTWIDTH - f_ue);
            f2i = f_sign ? (~f_mag + 1'b1) : f_mag;
        end
    end

    assign y   = way ? f2i : i2f;
    assign nan = f_nan;
    assign inf = f_inf;
endmodule

module cvt_fp_ctrl #(
    parameter int LOGWIDTH  = 5,
    parameter int EXPWIDTH  = 8,
    parameter int MANTWIDTH = 23,
    parameter int TAGWIDTH  = 5
) (
    input logic          ciClk,
    input logic          ciRst_n,
    cvt_fp_ctrl_if.slave bus
);
    localparam int W = 2**LOGWIDTH;

    if (W != EXPWIDTH + MANTWIDTH + 1) begin : g_bad_params
        $error("cvt_fp_ctrl: 2**LOGWIDTH must equal EXPWIDTH+MANTWIDTH+1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CONV = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [W-1:0]        op_a;
    logic                op_way;
    logic [TAGWIDTH-1:0] op_tag;
    logic [W-1:0]        y_q;
    logic [TAGWIDTH-1:0] tag_q;
    logic                nan_q;
    logic                inf_q;
    logic [W-1:0]        conv_y;
    logic                conv_nan;
    logic                conv_inf;
    logic                req_ready;
    logic                rsp_valid;
    logic                busy;
    logic                accept;
    logic                handoff;

    cvt_fp_conv #(
        .LOGWIDTH (LOGWIDTH),
        .EXPWIDTH (EXPWIDTH),
        .MANTWIDTH(MANTWIDTH)
    ) u_conv (
        .way(op_way),
        .a  (op_a),
        .y  (conv_y),
        .nan(conv_nan),
        .inf(conv_inf)
    );

    always_ff @(posedge ciClk) begin
        if (!ciRst_n) state <= IDLE;
        else          state <= state_next;
    end

    // Flush overrides every transition; the unused encoding falls back to IDLE.
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = accept ? CONV : IDLE;
            CONV:    state_next = DONE;
            DONE:    state_next = bus.ciRspReady ? (accept ? CONV : IDLE) : DONE;
            default: state_next = IDLE;
        endcase
        if (bus.ciFlush) state_next = IDLE;
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: req_ready = 1'b1;
            CONV: busy      = 1'b1;
            DONE: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                req_ready = bus.ciRspReady;
            end
            default: ;
        endcase
        req_ready = req_ready & ~bus.ciFlush & ciRst_n;
    end

    assign accept  = bus.ciReqValid & req_ready;
    assign handoff = (state == DONE) & bus.ciRspReady;

    always_ff @(posedge ciClk) begin
        if (!ciRst_n) begin
            op_a   <= '0;
            op_way <= 1'b0;
            op_tag <= '0;
            y_q    <= '0;
            tag_q  <= '0;
            nan_q  <= 1'b0;
            inf_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_a   <= bus.diA;
                op_way <= bus.ciWay;
                op_tag <= bus.diTag;
            end
            if (state == CONV && !bus.ciFlush) begin
                y_q   <= conv_y;
                tag_q <= op_tag;
                nan_q <= op_way & conv_nan;
                inf_q <= op_way & conv_inf;
            end
        end
    end

`ifdef CVT_FP_STICKY_FLAGS_EN
    logic sticky_nan;
    logic sticky_inf;

    // A setting handoff wins over a same-cycle clear.
    always_ff @(posedge ciClk) begin
        if (!ciRst_n) begin
            sticky_nan <= 1'b0;
            sticky_inf <= 1'b0;
        end else begin
            if (handoff && nan_q)   sticky_nan <= 1'b1;
            else if (bus.ciFlagClr) sticky_nan <= 1'b0;
            if (handoff && inf_q)   sticky_inf <= 1'b1;
            else if (bus.ciFlagClr) sticky_inf <= 1'b0;
        end
    end

    assign bus.doStickyNAN = sticky_nan;
    assign bus.doStickyINF = sticky_inf;
`else
    logic unused_handoff;
    assign unused_handoff = handoff;
`endif

    assign bus.coReqReady = req_ready;
    assign bus.coRspValid = rsp_valid;
    assign bus.coBusy     = busy;
    assign bus.doY        = y_q;
    assign bus.doTag      = tag_q;
    assign bus.doNAN      = nan_q;
    assign bus.doINF      = inf_q;
    assign bus.dbg_state  = state;
endmodule

// File: tb/tb_cvt_fp_ctrl.sv
// Directed bench for cvt_fp_ctrl: conversions, backpressure, flush and reset,
// plus sticky flags when CVT_FP_STICKY_FLAGS_EN is defined.
module tb_cvt_fp_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_asserts = 0;
  int n_fails = 0;

  always #5 clk = ~clk;

  cvt_fp_ctrl_if #(.W(32), .TAGWIDTH(5)) bus ();

  cvt_fp_ctrl #(
    .LOGWIDTH(5),
    .EXPWIDTH(8),
    .MANTWIDTH(23),
    .TAGWIDTH(5)
  ) dut (
    .ciClk(clk),
    .ciRst_n(rst_n),
    .bus(bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full transaction with no backpressure; inputs are scrambled after acceptance.
  task automatic run_op(input string name, input logic way, input logic [31:0] a,
                        input logic [4:0] tag, input logic [31:0] ey,
                        input logic en, input logic ei);
    bus.ciReqValid = 1'b1;
    bus.ciWay      = way;
    bus.diA        = a;
    bus.diTag      = tag;
    bus.ciRspReady = 1'b0;
    #1;
    chk1({name, " req_ready"}, bus.coReqReady, 1'b1);
    step();
    bus.ciReqValid = 1'b0;
    bus.ciWay      = ~way;
    bus.diA        = 32'hDEADBEEF;
    bus.diTag      = ~tag;
    #1;
    chk1({name, " conv busy"}, bus.coBusy, 1'b1);
    chk1({name, " conv rsp_valid"}, bus.coRspValid, 1'b0);
    step();
    chk1({name, " done rsp_valid"}, bus.coRspValid, 1'b1);
    chk32({name, " y"}, bus.doY, ey);
    chk32({name, " tag"}, 32'(bus.doTag), 32'(tag));
    chk1({name, " nan"}, bus.doNAN, en);
    chk1({name, " inf"}, bus.doINF, ei);
    bus.ciRspReady = 1'b1;
    step();
    bus.ciRspReady = 1'b0;
    #1;
    chk1({name, " after handoff rsp_valid"}, bus.coRspValid, 1'b0);
  endtask

  initial begin
    bus.ciReqValid = 1'b0;
    bus.ciWay      = 1'b0;
    bus.diA        = '0;
    bus.diTag      = '0;
    bus.ciRspReady = 1'b0;
    bus.ciFlush    = 1'b0;
`ifdef CVT_FP_STICKY_FLAGS_EN
    bus.ciFlagClr  = 1'b0;
`endif

    // Reset state
    step();
    step();
    bus.ciReqValid = 1'b1;
    #1;
    chk1("reset req_ready", bus.coReqReady, 1'b0);
    chk1("reset rsp_valid", bus.coRspValid, 1'b0);
    chk1("reset busy", bus.coBusy, 1'b0);
    chk32("reset y", bus.doY, 32'h0);
    chk32("reset tag", 32'(bus.doTag), 32'h0);
    chk1("reset nan", bus.doNAN, 1'b0);
    chk1("reset inf", bus.doINF, 1'b0);
    step();
    chk1("reset not accepted busy", bus.coBusy, 1'b0);
    bus.ciReqValid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk1("post reset req_ready", bus.coReqReady, 1'b1);

    // Directed conversions
    run_op("w2f one",      1'b0, 32'h00000001, 5'd3,  32'h3F800000, 1'b0, 1'b0);
    run_op("w2f minus1",   1'b0, 32'hFFFFFFFF, 5'd4,  32'hBF800000, 1'b0, 1'b0);
    run_op("f2w pi",       1'b1, 32'h40490FDB, 5'd5,  32'h00000003, 1'b0, 1'b0);
    run_op("f2w +inf",     1'b1, 32'h7F800000, 5'd6,  32'h7FFFFFFF, 1'b0, 1'b1);
    run_op("f2w qnan",     1'b1, 32'h7FC00000, 5'd7,  32'h7FFFFFFF, 1'b1, 1'b0);
`ifdef CVT_FP_STICKY_FLAGS_EN
    chk1("sticky nan set", bus.doStickyNAN, 1'b1);
    chk1("sticky inf set", bus.doStickyINF, 1'b1);
    step();
    chk1("sticky nan holds", bus.doStickyNAN, 1'b1);
    bus.ciFlagClr = 1'b1;
    step();
    bus.ciFlagClr = 1'b0;
    #1;
    chk1("sticky nan cleared", bus.doStickyNAN, 1'b0);
    chk1("sticky inf cleared", bus.doStickyINF, 1'b0);
`endif
    run_op("w2f zero",     1'b0, 32'h00000000, 5'd8,  32'h00000000, 1'b0, 1'b0);
    run_op("w2f intmin",   1'b0, 32'h80000000, 5'd9,  32'hCF000000, 1'b0, 1'b0);
    run_op("w2f tie even", 1'b0, 32'h01000001, 5'd10, 32'h4B800000, 1'b0, 1'b0);
    run_op("w2f tie up",   1'b0, 32'h01000003, 5'd11, 32'h4B800002, 1'b0, 1'b0);
    run_op("w2f intmax",   1'b0, 32'h7FFFFFFF, 5'd12, 32'h4F000000, 1'b0, 1'b0);
    run_op("f2w -pi",      1'b1, 32'hC0490FDB, 5'd13, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("f2w half",     1'b1, 32'h3F000000, 5'd14, 32'h00000000, 1'b0, 1'b0);
    run_op("f2w 2^31",     1'b1, 32'h4F000000, 5'd15, 32'h7FFFFFFF, 1'b0, 1'b1);
    run_op("f2w -2^31",    1'b1, 32'hCF000000, 5'd16, 32'h80000000, 1'b0, 1'b0);
    run_op("f2w -inf",     1'b1, 32'hFF800000, 5'd17, 32'h80000000, 1'b0, 1'b1);
    run_op("w2f nan bits", 1'b0, 32'h7FC00000, 5'd18, 32'h4EFF8000, 1'b0, 1'b0);

`ifdef CVT_FP_STICKY_FLAGS_EN
    // Set on the handoff edge beats a clear held through the whole operation
    bus.ciFlagClr = 1'b1;
    run_op("sticky set wins", 1'b1, 32'h7FC00000, 5'd19, 32'h7FFFFFFF, 1'b1, 1'b0);
    chk1("sticky set over clear", bus.doStickyNAN, 1'b1);
    bus.ciFlagClr = 1'b0;
`endif

    // Backpressure then back-to-back handoff and acceptance
    bus.ciReqValid = 1'b1;
    bus.ciWay      = 1'b0;
    bus.diA        = 32'h00000005;
    bus.diTag      = 5'd7;
    step();
    bus.ciWay      = 1'b1;
    bus.diA        = 32'h41200000;
    bus.diTag      = 5'd9;
    step();
    for (int i = 0; i < 5; i++) begin
      chk1("bp rsp_valid", bus.coRspValid, 1'b1);
      chk32("bp y stable", bus.doY, 32'h40A00000);
      chk1("bp req_ready", bus.coReqReady, 1'b0);
      step();
    end
    bus.ciRspReady = 1'b1;
    #1;
    chk1("bp handoff req_ready", bus.coReqReady, 1'b1);
    chk32("bp handoff tag", 32'(bus.doTag), 32'd7);
    step();
    bus.ciReqValid = 1'b0;
    bus.ciRspReady = 1'b0;
    #1;
    chk1("bp second conv rsp_valid", bus.coRspValid, 1'b0);
    chk1("bp second conv busy", bus.coBusy, 1'b1);
    step();
    chk1("bp second rsp_valid", bus.coRspValid, 1'b1);
    chk32("bp second y", bus.doY, 32'h0000000A);
    chk32("bp second tag", 32'(bus.doTag), 32'd9);
    bus.ciRspReady = 1'b1;
    step();
    bus.ciRspReady = 1'b0;

    // Flush in CONV
    bus.ciReqValid = 1'b1;
    bus.ciWay      = 1'b0;
    bus.diA        = 32'h00000002;
    bus.diTag      = 5'd1;
    step();
    bus.ciReqValid = 1'b0;
    bus.ciFlush    = 1'b1;
    #1;
    chk1("flush conv req_ready", bus.coReqReady, 1'b0);
    step();
    bus.ciFlush = 1'b0;
    bus.ciRspReady = 1'b1;
    #1;
    chk1("flush conv busy", bus.coBusy, 1'b0);
    chk1("flush conv rsp_valid", bus.coRspValid, 1'b0);
    step();
    chk1("flush conv no late rsp", bus.coRspValid, 1'b0);
    bus.ciRspReady = 1'b0;

    // Flush with a request in IDLE
    bus.ciReqValid = 1'b1;
    bus.ciFlush    = 1'b1;
    #1;
    chk1("flush idle req_ready", bus.coReqReady, 1'b0);
    step();
    bus.ciReqValid = 1'b0;
    bus.ciFlush    = 1'b0;
    #1;
    chk1("flush idle busy", bus.coBusy, 1'b0);

    // Flush together with a DONE handoff and a pending request
    bus.ciReqValid = 1'b1;
    bus.diA        = 32'h00000003;
    step();
    bus.ciReqValid = 1'b0;
    step();
    chk1("flush done rsp_valid", bus.coRspValid, 1'b1);
    chk32("flush done y", bus.doY, 32'h40400000);
    bus.ciRspReady = 1'b1;
    bus.ciReqValid = 1'b1;
    bus.ciFlush    = 1'b1;
    #1;
    chk1("flush done req_ready", bus.coReqReady, 1'b0);
    step();
    bus.ciRspReady = 1'b0;
    bus.ciReqValid = 1'b0;
    bus.ciFlush    = 1'b0;
    #1;
    chk1("flush done busy", bus.coBusy, 1'b0);
    chk1("flush done rsp cleared", bus.coRspValid, 1'b0);

    // Reset while DONE
    bus.ciReqValid = 1'b1;
    bus.ciWay      = 1'b1;
    bus.diA        = 32'h7F800000;
    bus.diTag      = 5'd31;
    step();
    bus.ciReqValid = 1'b0;
    step();
    chk1("pre reset inf", bus.doINF, 1'b1);
    chk32("pre reset tag", 32'(bus.doTag), 32'd31);
    rst_n = 1'b0;
    #1;
    chk1("in reset req_ready", bus.coReqReady, 1'b0);
    step();
    chk1("reset done rsp_valid", bus.coRspValid, 1'b0);
    chk1("reset done busy", bus.coBusy, 1'b0);
    chk32("reset done y", bus.doY, 32'h0);
    chk32("reset done tag", 32'(bus.doTag), 32'h0);
    chk1("reset done nan", bus.doNAN, 1'b0);
    chk1("reset done inf", bus.doINF, 1'b0);
`ifdef CVT_FP_STICKY_FLAGS_EN
    chk1("reset sticky nan", bus.doStickyNAN, 1'b0);
    chk1("reset sticky inf", bus.doStickyINF, 1'b0);
`endif
    rst_n = 1'b1;
    bus.ciRspReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("post reset no rsp", bus.coRspValid, 1'b0);
    end
    bus.ciRspReady = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule

// File: doc/cvt_fp_ctrl.md
CVT_FP_CTRL -- requirements
Module: cvt_fp_ctrl

Interface
REQ-001 Parameters SHALL be: LOGWIDTH, default 5, log2 of datapath width W; EXPWIDTH, default 8, exponent width; MANTWIDTH, default 23, mantissa width; TAGWIDTH, default 5, destination-register tag width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- ciClk, in, 1: the single clock.
- ciRst_n, in, 1: synchronous, active-low reset.
- ciReqValid, in, 1: request present.
- coReqReady, out, 1: request accepted this cycle when high together with ciReqValid.
- ciWay, in, 1: 0 = cvt.s.w (word to float), 1 = cvt.w.s (float to word).
- diA, in, W: operand.
- diTag, in, TAGWIDTH: destination tag.
- coRspValid, out, 1: result valid.
- ciRspReady, in, 1: consumer takes the result.
- doY, out, W: result.
- doTag, out, TAGWIDTH: tag of the result.
- doNAN, out, 1: NaN input on cvt.w.s.
- doINF, out, 1: overflow or infinity on cvt.w.s.
- ciFlush, in, 1: kill the in-flight operation.
- coBusy, out, 1: state is not IDLE.
REQ-003 W SHALL equal 2**LOGWIDTH, and W SHALL equal EXPWIDTH+MANTWIDTH+1. An illegal parameter set SHALL fail elaboration.

Function
REQ-004 The block SHALL instantiate exactly one combinational IEEE-754 int/float converter, carrying the same parameters, and SHALL sequence it as a 2-tick operation.
REQ-005 The FSM SHALL have exactly 3 states: IDLE, CONV and DONE.
REQ-006 IDLE SHALL go to CONV on acceptance. At acceptance the block SHALL register diA, ciWay and diTag into the operand stage.
REQ-007 CONV SHALL last exactly 1 cycle. The converter SHALL evaluate the registered operand, and doY, doNAN and doINF SHALL be registered on leaving CONV for DONE.
REQ-008 DONE SHALL hold coRspValid=1 and keep doY, doTag, doNAN and doINF stable until ciRspReady=1.
- On handoff the FSM SHALL go to CONV if a new request is accepted in the same cycle, otherwise to IDLE.
REQ-009 coReqReady SHALL be (IDLE or (DONE and ciRspReady)) and not ciFlush.
REQ-010 Latency SHALL be fixed: request accepted at edge N gives coRspValid=1 from edge N+2. Peak throughput SHALL be 1 operation per 2 cycles.
REQ-011 doNAN and doINF SHALL be forced to 0 for ciWay=0 results.
REQ-012 A ciReqValid that is not accepted SHALL leave all state unchanged. The requester SHALL hold its inputs stable, and the block SHALL NOT depend on that.
REQ-013 ciFlush=1 SHALL return the FSM to IDLE at the next edge from any state and clear coRspValid, with no result delivered.
REQ-014 When ciFlush=1 coincides with ciReqValid=1, flush SHALL win and the request SHALL NOT be accepted.
REQ-015 When ciFlush=1 coincides with a DONE handoff, the handoff SHALL still complete in that cycle.
REQ-016 coBusy SHALL be 1 in CONV and DONE.
REQ-017 The FSM SHALL never occupy an encoding outside the 3 states. Any illegal encoding SHALL recover to IDLE at the next edge.

Reset
REQ-018 ciRst_n=0 sampled at a clock edge SHALL force: IDLE, coRspValid=0, coBusy=0, doY=0, doTag=0, doNAN=0, doINF=0, and sticky flags=0.
REQ-019 coReqReady SHALL be 0 while ciRst_n=0.
REQ-020 Reset mid-operation SHALL discard the operation with no response.
REQ-021 Reset SHALL NOT act asynchronously.

Configuration
REQ-022 Macro CVT_FP_STICKY_FLAGS_EN, when defined, SHALL add these ports:
- ciFlagClr, in, 1.
- doStickyNAN, out, 1.
- doStickyINF, out, 1.
REQ-023 With the macro defined, the sticky flags SHALL set on each handoff whose doNAN or doINF is 1. They SHALL clear on ciFlagClr=1, and set SHALL win over a same-cycle clear. Flushed operations SHALL NOT set the flags.
REQ-024 Without the macro, those ports and registers SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-025 ciWay=0, diA=0x00000001, tag 3 -> 2 cycles later doY=0x3F800000, doTag=3, doNAN=0, doINF=0.
REQ-026 ciWay=0, diA=0xFFFFFFFF -> doY=0xBF800000. Then ciWay=1, diA=0x40490FDB -> doY=0x00000003.
REQ-027 ciWay=1, diA=0x7F800000 -> doINF=1, doNAN=0. ciWay=1, diA=0x7FC00000 -> doNAN=1. With CVT_FP_STICKY_FLAGS_EN, both sticky flags =1 until ciFlagClr.
REQ-028 Backpressure: ciRspReady=0 for 5 cycles in DONE -> doY stable, coReqReady=0. Then ciRspReady=1 with ciReqValid=1 -> handoff and acceptance in the same cycle, next response 2 cycles later.
REQ-029 ciFlush in CONV -> no coRspValid. ciFlush together with ciReqValid in IDLE -> coReqReady=0, FSM stays IDLE.
REQ-030 ciRst_n=0 asserted in DONE -> all outputs 0 at the next edge, no response after release.
